// File: rtl/ovl_pkg.sv
// ovl_pkg: shared constants, ARGB4444 layout and loader FSM encoding
// for the overlay picture store writer.
package ovl_pkg;
   localparam logic [7:0] OVL_INDEX  = 8'd2;
   localparam logic [7:0] PAD_BYTE   = 8'h00;
   localparam int         ARGB_R_LSB = 0;
   localparam int         ARGB_G_LSB = 4;
   localparam int         ARGB_B_LSB = 8;
   localparam int         ARGB_A_LSB = 12;

   typedef enum logic [2:0] {
      S_IDLE, S_LO, S_HI, S_ISSUE, S_GUARD, S_WAIT, S_FLUSH, S_DONE
   } ovl_state_t;

   // Even byte carries {G,R}, odd byte carries {A,B}.
   function automatic logic [15:0] argb_word(input logic [7:0] even_b, input logic [7:0] odd_b);
      argb_word = '0;
      argb_word[ARGB_R_LSB+:4] = even_b[3:0];
      argb_word[ARGB_G_LSB+:4] = even_b[7:4];
      argb_word[ARGB_B_LSB+:4] = odd_b[3:0];
      argb_word[ARGB_A_LSB+:4] = odd_b[7:4];
   endfunction
endpackage

// File: rtl/ovl_byte_packer.sv
// ovl_byte_packer: pairs even/odd ioctl bytes into ARGB4444 words;
// an unpaired byte is padded with zero (a lone even byte becomes transparent).
module ovl_byte_packer
   import ovl_pkg::*;
#(
   parameter int ADDR_W = 25
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              clear_i,
   input  logic              take_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [7:0]        data_i,
   output logic              word_v_o,
   output logic [ADDR_W-1:0] word_addr_o,
   output logic [15:0]       word_o
);
   logic              has_q;
   logic [7:0]        lo_q;
   logic [ADDR_W-2:0] waddr_q;
   logic              odd, match;

   assign odd         = addr_i[0];
   assign match       = has_q && addr_i[ADDR_W-1:1] == waddr_q;
   assign word_v_o    = (take_i && odd) || (flush_i && has_q);
   assign word_addr_o = flush_i ? {waddr_q, 1'b0} : {addr_i[ADDR_W-1:1], 1'b0};
   assign word_o      = flush_i ? argb_word(lo_q, PAD_BYTE) : argb_word(match ? lo_q : PAD_BYTE, data_i);

   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         has_q   <= 1'b0;
         lo_q    <= '0;
         waddr_q <= '0;
      end else if (clear_i) begin
         has_q <= 1'b0;
      end else if (take_i && !odd) begin
         has_q   <= 1'b1;
         lo_q    <= data_i;
         waddr_q <= addr_i[ADDR_W-1:1];
      end else if (word_v_o) begin
         has_q <= 1'b0;
      end
endmodule

// File: rtl/overlay_loader.sv
// overlay_loader: writes the HPS overlay download into SDRAM as ARGB4444 words,
// stalling the HPS while a write is outstanding, and flags a completed overlay.
module overlay_loader #(
   parameter logic [7:0] OVL_INDEX = ovl_pkg::OVL_INDEX,
   parameter int         ADDR_W    = 25,
   parameter int         MAX_BYTES = 1048576
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   input  logic [15:0]       sdram_sz,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_din,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic              overlay_valid,
   output logic [ADDR_W-2:0] overlay_words,
   output logic              overlay_ovf
);
   import ovl_pkg::*;

   localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_BYTES);

   ovl_state_t        state_q, state_d;
   logic              active, present, hold, busy, take, drop, flush, start;
   logic              word_v;
   logic [ADDR_W-1:0] word_addr;
   logic [15:0]       word;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [15:0]       mem_din_q;
   logic              mem_we_q, valid_q, ovf_q, end_q;
   logic [ADDR_W-2:0] words_q;
   logic              unused_sz;

   assign active    = ioctl_download && ioctl_index == OVL_INDEX;
   assign present   = |sdram_sz[2:0];
   assign unused_sz = ^sdram_sz[15:3];
   assign hold      = state_q == S_LO || state_q == S_HI;
   assign busy      = state_q == S_ISSUE || state_q == S_GUARD || state_q == S_WAIT;
   assign take      = hold && active && ioctl_wr && ioctl_addr < MAX_A;
   assign drop      = hold && active && ioctl_wr && ioctl_addr >= MAX_A;
   assign flush     = state_q == S_FLUSH;
   assign start     = state_q == S_IDLE && active;

   ovl_byte_packer #(.ADDR_W(ADDR_W)) u_packer (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .clear_i    (start),
      .take_i     (take),
      .flush_i    (flush),
      .addr_i     (ioctl_addr),
      .data_i     (ioctl_dout),
      .word_v_o   (word_v),
      .word_addr_o(word_addr),
      .word_o     (word)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     state_d = active ? S_LO : S_IDLE;
         S_LO, S_HI: state_d = !active ? (state_q == S_HI ? S_FLUSH : S_DONE) :
                               word_v  ? (present ? S_ISSUE : S_LO) :
                               take    ? S_HI : state_q;
         S_FLUSH:    state_d = present ? S_ISSUE : S_DONE;
         S_ISSUE:    state_d = mem_ready ? S_GUARD : S_ISSUE;
         S_GUARD:    state_d = S_WAIT;
         S_WAIT:     state_d = !mem_ready ? S_WAIT : (end_q || !active) ? S_DONE : S_LO;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // end_q remembers a download that ended while a write was still in flight.
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         state_q    <= S_IDLE;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_we_q   <= 1'b0;
         words_q    <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         end_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         mem_we_q <= state_q == S_ISSUE && mem_ready;
         end_q    <= busy ? (end_q || !active) : flush;
         if (word_v) begin
            mem_addr_q <= word_addr;
            mem_din_q  <= word;
         end
         if (start) begin
            words_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
         end else begin
            if (state_q == S_WAIT && mem_ready && !(&words_q)) words_q <= words_q + 1'b1;
            if (drop) ovf_q <= 1'b1;
            if (state_q == S_DONE) valid_q <= |words_q && present;
         end
      end

   assign ioctl_wait    = busy;
   assign mem_addr      = mem_addr_q;
   assign mem_din       = mem_din_q;
   assign mem_we        = mem_we_q;
   assign overlay_valid = valid_q;
   assign overlay_words = words_q;
   assign overlay_ovf   = ovf_q;
endmodule
